// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, symmetric debounce FSM,
// registered press/release/long-press strobes and a debounced pressed level.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned LONG_CYCLES     = 27000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic              IDLE_PAD  = BTN_ACTIVE_LOW;
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_t;

    state_t              state, state_next;
    logic [1:0]          sync;
    logic                s_pressed;
    logic [DB_W-1:0]     db_cnt, db_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic                level_next, press_next, release_next, long_next;

    // Synchroniser resets to the idle pad level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{IDLE_PAD}};
        end else begin
            sync <= {sync[0], btn_raw};
        end
    end

    assign s_pressed = sync[1] ^ IDLE_PAD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_next;
            db_cnt        <= db_next;
            hold_cnt      <= hold_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            long_pulse    <= long_next;
        end
    end

    always_comb begin
        state_next   = state;
        db_next      = db_cnt;
        hold_next    = hold_cnt;
        level_next   = btn_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;

        // Hold time keeps running through a release bounce; saturates, never wraps.
        if ((state == PRESSED || state == DB_RELEASE) && hold_cnt != HOLD_MAX) begin
            hold_next = hold_cnt + HOLD_W'(1);
            long_next = (hold_cnt == HOLD_LAST);
        end

        case (state)
            IDLE: begin
                level_next = 1'b0;
                if (s_pressed) begin
                    state_next = DB_PRESS;
                    db_next    = DB_W'(1);
                end
            end
            DB_PRESS: begin
                if (!s_pressed) begin
                    state_next = IDLE;
                    db_next    = '0;
                end else if (db_cnt == DB_MAX) begin
                    state_next = PRESSED;
                    db_next    = '0;
                    hold_next  = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    db_next = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!s_pressed) begin
                    state_next = DB_RELEASE;
                    db_next    = DB_W'(1);
                end
            end
            DB_RELEASE: begin
                if (s_pressed) begin
                    state_next = PRESSED;
                    db_next    = '0;
                end else if (db_cnt == DB_MAX) begin
                    state_next   = IDLE;
                    db_next      = '0;
                    hold_next    = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                    long_next    = 1'b0;
                end else begin
                    db_next = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                db_next    = '0;
                hold_next  = '0;
                level_next = 1'b0;
            end
        endcase
    end

endmodule
